// File: rtl/posit_encoder.sv
// Packs a decoded posit (sign, regime k, exponent, fraction, sticky, specials)
// into a WIDTH-bit posit with round-to-nearest-even and saturation; 2-stage pipeline.
module posit_encoder #(
    parameter int WIDTH  = 8,
    parameter int EXP    = 2,
    parameter int FRAC_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn,
    input  logic                     vld_i,
    output logic                     rdy_o,
    input  logic                     sign_i,
    input  logic [$clog2(WIDTH):0]   regi_i,
    input  logic [EXP-1:0]           exp_i,
    input  logic [FRAC_W-1:0]        frac_i,
    input  logic                     sticky_i,
    input  logic                     zero_i,
    input  logic                     nar_i,
    output logic [WIDTH-1:0]         posit_o,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic                     sat_o
);

    localparam int KW = $clog2(WIDTH) + 1;
    localparam int TW = EXP + FRAC_W;
    localparam int LW = WIDTH + TW;
    localparam int SW = $clog2(LW + 1);
    localparam logic [WIDTH-2:0] MAXPOS = '1;
    localparam logic [WIDTH-2:0] MINPOS = (WIDTH-1)'(1);

    logic w_en1, w_en2;
    logic r_vld_s1;

    assign w_en2 = ~vld_o | rdy_i;
    assign w_en1 = ~r_vld_s1 | w_en2;
    assign rdy_o = w_en1;

    // Stage 1: left-pack regime | exponent | fraction into one long bit string
    logic          w_k_neg;
    logic [KW-1:0] w_kabs;
    logic          w_ovf, w_unf;
    logic [SW-1:0] w_rlen;
    logic [LW-1:0] w_regime, w_tail, w_str;

    assign w_k_neg  = regi_i[KW-1];
    assign w_kabs   = w_k_neg ? (~regi_i + KW'(1)) : regi_i;
    assign w_ovf    = ~w_k_neg & (w_kabs > KW'(WIDTH-2));
    assign w_unf    = w_k_neg & (w_kabs > KW'(WIDTH-2));
    assign w_rlen   = w_k_neg ? (SW'(w_kabs) + SW'(1)) : (SW'(w_kabs) + SW'(2));
    assign w_regime = w_k_neg ? ({1'b1, {(LW-1){1'b0}}} >> w_kabs)
                              : ~({LW{1'b1}} >> (SW'(w_kabs) + SW'(1)));
    assign w_tail   = {exp_i, frac_i, {WIDTH{1'b0}}} >> w_rlen;
    assign w_str    = w_regime | w_tail;

    logic [WIDTH-2:0] r_mag;
    logic             r_guard, r_sticky, r_sign, r_zero, r_nar, r_ovf, r_unf;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_vld_s1 <= 1'b0;
            r_mag    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_nar    <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (w_en1) begin
            r_vld_s1 <= vld_i;
            if (vld_i) begin
                r_mag    <= w_str[LW-1 -: WIDTH-1];
                r_guard  <= w_str[LW-WIDTH];
                r_sticky <= (|w_str[LW-WIDTH-1:0]) | sticky_i;
                r_sign   <= sign_i;
                r_zero   <= zero_i;
                r_nar    <= nar_i;
                r_ovf    <= w_ovf;
                r_unf    <= w_unf;
            end
        end
    end

    // Stage 2: round-to-nearest-even, then clamp; rounding up onto maxpos counts as saturation
    logic             w_inc, w_rnd_sat, w_sat;
    logic [WIDTH-1:0] w_sum, w_mag_ext, w_posit;
    logic [WIDTH-2:0] w_mag_fin;

    assign w_inc     = r_guard & (r_sticky | r_mag[0]);
    assign w_sum     = {1'b0, r_mag} + WIDTH'(w_inc);
    assign w_rnd_sat = w_inc & (w_sum[WIDTH-1] | (w_sum[WIDTH-2:0] == MAXPOS));

    always_comb begin
        w_sat     = 1'b0;
        w_mag_fin = w_sum[WIDTH-2:0];
        if (r_ovf) begin
            w_mag_fin = MAXPOS;
            w_sat     = 1'b1;
        end else if (r_unf) begin
            w_mag_fin = MINPOS;
            w_sat     = 1'b1;
        end else if (w_rnd_sat) begin
            w_mag_fin = MAXPOS;
            w_sat     = 1'b1;
        end else if (w_sum[WIDTH-2:0] == '0) begin
            w_mag_fin = MINPOS;
            w_sat     = 1'b1;
        end
        w_mag_ext = {1'b0, w_mag_fin};
        w_posit   = r_sign ? (~w_mag_ext + WIDTH'(1)) : w_mag_ext;
        if (r_nar) begin
            w_posit = {1'b1, {(WIDTH-1){1'b0}}};
            w_sat   = 1'b0;
        end else if (r_zero) begin
            w_posit = '0;
            w_sat   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            vld_o   <= 1'b0;
            posit_o <= '0;
            sat_o   <= 1'b0;
        end else if (w_en2) begin
            vld_o <= r_vld_s1;
            if (r_vld_s1) begin
                posit_o <= w_posit;
                sat_o   <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_posit_encoder.sv
// Scoreboard bench for posit_encoder: directed known answers, random stream vs
// a bit-queue reference model, backpressure and mid-stream reset.
module tb_posit_encoder;
    localparam int W  = 8;
    localparam int E  = 2;
    localparam int F  = 8;
    localparam int KW = $clog2(W) + 1;

    logic          clk_i = 1'b0;
    logic          rstn, vld_i, rdy_o, sign_i, sticky_i, zero_i, nar_i;
    logic [KW-1:0] regi_i;
    logic [E-1:0]  exp_i;
    logic [F-1:0]  frac_i;
    logic [W-1:0]  posit_o;
    logic          vld_o, rdy_i, sat_o;

    posit_encoder #(.WIDTH(W), .EXP(E), .FRAC_W(F)) dut (
        .clk_i(clk_i), .rstn(rstn), .vld_i(vld_i), .rdy_o(rdy_o),
        .sign_i(sign_i), .regi_i(regi_i), .exp_i(exp_i), .frac_i(frac_i),
        .sticky_i(sticky_i), .zero_i(zero_i), .nar_i(nar_i),
        .posit_o(posit_o), .vld_o(vld_o), .rdy_i(rdy_i), .sat_o(sat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int p; bit sat; int cyc; bit chk_lat; } exp_t;
    typedef struct { bit s; int k; int e; int f; bit st; bit z; bit n; int p; bit sat; } dir_t;

    localparam int ND = 22;
    dir_t dir_tab [ND] = '{
        '{0,  0, 0, 'h00, 0, 0, 0, 'h40, 0},
        '{1,  0, 0, 'h00, 0, 0, 0, 'hC0, 0},
        '{0,  1, 3, 'h80, 0, 0, 0, 'h6E, 0},
        '{0,  0, 0, 'h10, 0, 0, 0, 'h40, 0},
        '{0,  0, 0, 'h30, 0, 0, 0, 'h42, 0},
        '{0,  0, 0, 'h11, 0, 0, 0, 'h41, 0},
        '{0,  0, 0, 'h10, 1, 0, 0, 'h41, 0},
        '{0,  0, 0, 'hF8, 0, 0, 0, 'h48, 0},
        '{0,  6, 3, 'hFF, 1, 0, 0, 'h7F, 0},
        '{0,  7, 0, 'h00, 0, 0, 0, 'h7F, 1},
        '{0,  5, 3, 'hFF, 0, 0, 0, 'h7F, 1},
        '{0, -6, 0, 'h00, 0, 0, 0, 'h01, 0},
        '{0, -7, 0, 'h00, 0, 0, 0, 'h01, 1},
        '{1, -7, 0, 'h00, 0, 0, 0, 'hFF, 1},
        '{0,  0, 0, 'h00, 0, 1, 0, 'h00, 0},
        '{0,  0, 0, 'h00, 0, 0, 1, 'h80, 0},
        '{0,  0, 0, 'h00, 0, 1, 1, 'h80, 0},
        '{1,  3, 1, 'h55, 0, 0, 1, 'h80, 0},
        '{1,  6, 0, 'h00, 0, 0, 0, 'h81, 0},
        '{0, -8, 2, 'hAB, 1, 0, 0, 'h01, 1},
        '{1,  0, 0, 'h30, 0, 0, 0, 'hBE, 0},
        '{0, -1, 2, 'h40, 0, 0, 0, 'h32, 0}
    };

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0, n_pass = 0, cyc = 0;
    bit   lat_mode = 1'b0, saw_drop = 1'b0;
    int   cur_p;
    bit   cur_sat;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: spell the posit out bit by bit, then round on integers
    function automatic void model(input bit s, input int k, input int e, input int f,
                                  input bit st, input bit z, input bit n,
                                  output int p, output bit sat);
        bit bits[$];
        int mag;
        bit g, stk;
        int maxpos = (1 << (W-1)) - 1;
        sat = 1'b0;
        p   = 0;
        if (n) begin p = 1 << (W-1); return; end
        if (z) return;
        if (k > W-2) begin
            mag = maxpos; sat = 1'b1;
        end else if (k < -(W-2)) begin
            mag = 1; sat = 1'b1;
        end else begin
            if (k >= 0) begin
                repeat (k+1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            for (int i = E-1; i >= 0; i--) bits.push_back(((e >> i) & 1) != 0);
            for (int i = F-1; i >= 0; i--) bits.push_back(((f >> i) & 1) != 0);
            mag = 0;
            for (int i = 0; i < W-1; i++) mag = mag*2 + int'(bits[i]);
            g   = bits[W-1];
            stk = st;
            for (int i = W; i < bits.size(); i++) stk |= bits[i];
            if (g && (stk || (mag % 2 == 1))) begin
                mag++;
                if (mag >= maxpos) begin mag = maxpos; sat = 1'b1; end
            end
            if (mag == 0) begin mag = 1; sat = 1'b1; end
        end
        p = s ? ((1 << W) - mag) : mag;
    endfunction

    task automatic drive(input bit s, input int k, input int e, input int f,
                         input bit st, input bit z, input bit n, input int xp, input bit xs);
        sign_i = s; regi_i = KW'(k); exp_i = E'(e); frac_i = F'(f);
        sticky_i = st; zero_i = z; nar_i = n;
        cur_p = xp; cur_sat = xs;
        vld_i = 1'b1;
    endtask

    task automatic drive_rand(input bit allow_special);
        int k, e, f, p;
        bit s, st, z, n, sat;
        k  = int'($urandom_range(0, 15));
        if (k > 7) k -= 16;
        e  = int'($urandom_range(0, 3));
        f  = int'($urandom_range(0, 255));
        s  = $urandom_range(0, 1) != 0;
        st = $urandom_range(0, 1) != 0;
        z  = allow_special && ($urandom_range(0, 19) == 0);
        n  = allow_special && ($urandom_range(0, 19) == 0);
        model(s, k, e, f, st, z, n, p, sat);
        drive(s, k, e, f, st, z, n, p, sat);
    endtask

    // Holds the current input until accepted
    task automatic send(input bit rnd_rdy);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk_i);
            if (rdy_o) return;
            @(posedge clk_i);
            #1;
            if (rnd_rdy) rdy_i = $urandom_range(0, 3) != 0;
        end
        check("accept_timeout", int'(rdy_o), 1);
    endtask

    task automatic drain();
        vld_i = 1'b0;
        rdy_i = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk_i);
            if (sb.size() == 0) break;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rstn = 1'b0; vld_i = 1'b0; rdy_i = 1'b1;
        sign_i = 1'b0; regi_i = '0; exp_i = '0; frac_i = '0;
        sticky_i = 1'b0; zero_i = 1'b0; nar_i = 1'b0;
        cur_p = 0; cur_sat = 1'b0;

        fork
            forever begin
                @(posedge clk_i);
                cyc++;
            end
            forever begin
                @(negedge clk_i);
                if (!rstn) sb.delete();
                else begin
                    if (vld_o) begin
                        if (sb.size() == 0) check("unexpected_output", 0, 1);
                        else if (rdy_i) begin
                            mon_e = sb.pop_front();
                            check("posit", int'(posit_o), mon_e.p);
                            check("sat", int'(sat_o), int'(mon_e.sat));
                            if (mon_e.chk_lat) check("latency", cyc - mon_e.cyc, 2);
                        end else begin
                            check("stall_posit", int'(posit_o), sb[0].p);
                            check("stall_sat", int'(sat_o), int'(sb[0].sat));
                        end
                    end
                    if (vld_i && rdy_o) sb.push_back('{cur_p, cur_sat, cyc, lat_mode});
                end
            end
        join_none

        #12;
        check("rst_posit", int'(posit_o), 0);
        check("rst_vld", int'(vld_o), 0);
        check("rst_sat", int'(sat_o), 0);
        check("rst_rdy", int'(rdy_o), 1);
        @(negedge clk_i);
        rstn = 1'b1;

        // directed known answers, back-to-back
        lat_mode = 1'b1;
        for (int i = 0; i < ND; i++) begin
            @(posedge clk_i);
            #1;
            drive(dir_tab[i].s, dir_tab[i].k, dir_tab[i].e, dir_tab[i].f, dir_tab[i].st,
                  dir_tab[i].z, dir_tab[i].n, dir_tab[i].p, dir_tab[i].sat);
            send(1'b0);
        end
        @(posedge clk_i);
        #1;
        drain();

        // random stream with random backpressure
        lat_mode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i);
            #1;
            rdy_i = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 9) < 7) begin
                drive_rand(1'b1);
                send(1'b1);
            end else vld_i = 1'b0;
        end
        @(posedge clk_i);
        #1;
        drain();

        // 5 back-to-back items with downstream stalled for cycles 3..6
        begin
            int sent = 0;
            for (int j = 0; j < 40 && sent < 5; j++) begin
                @(posedge clk_i);
                #1;
                rdy_i = !(j >= 3 && j <= 6);
                drive_rand(1'b0);
                @(negedge clk_i);
                if (rdy_o) sent++;
                else saw_drop = 1'b1;
            end
            check("bp_sent", sent, 5);
            check("bp_rdy_dropped", int'(saw_drop), 1);
        end
        @(posedge clk_i);
        #1;
        drain();

        // reset with two items in flight
        lat_mode = 1'b1;
        @(posedge clk_i);
        #1;
        drive_rand(1'b0);
        send(1'b0);
        @(posedge clk_i);
        #1;
        drive_rand(1'b0);
        send(1'b0);
        @(posedge clk_i);
        #1;
        vld_i = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_vld", int'(vld_o), 0);
        check("mid_rst_posit", int'(posit_o), 0);
        check("mid_rst_rdy", int'(rdy_o), 1);
        @(posedge clk_i);
        #3;
        rstn = 1'b1;
        @(posedge clk_i);
        #1;
        drive_rand(1'b1);
        send(1'b0);
        @(posedge clk_i);
        #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
